riio_vsup_seq: RTL
==================

# riio_vsup_seq

Parametrised multi-channel IO supply sequencer for the GF22FDX IO ring. It drives the power-switch enables of `N_CH` IO supply segments. Power-up runs in ascending channel order, gated by per-channel settle time and power-good feedback. Power-down runs in descending order. It holds core/IO isolation until every segment is good, and reports faults with the failing channel index.

## Interface
Parameters:
- `N_CH`, 4: number of supply channels (≥1)
- `CNT_W`, 12: settle/timeout counter width
- `SETTLE_CYC`, 100: cycles per channel between switch change and next action (1..2^CNT_W−1)
- `TIMEOUT_CYC`, 1000: power-good timeout in cycles (1..2^CNT_W−1)

Ports. One clock; reset is synchronous and active-high.
- `clk` in 1: clock
- `rst` in 1: synchronous active-high reset
- `pwr_req_i` in 1: level request, 1 = supplies on
- `pg_i` in N_CH: per-channel power-good, pre-synchronised to `clk`
- `clr_fault_i` in 1: fault clear pulse
- `sw_en_o` out N_CH: power-switch enables, registered
- `iso_o` out 1: isolation, 1 = isolated
- `ready_o` out 1: all channels up and good
- `busy_o` out 1: sequencing in progress
- `fault_o` out 1: sticky fault
- `fault_ch_o` out max(1,$clog2(N_CH)): channel index that faulted

## Operation
- Reset values: `sw_en_o`=0, `iso_o`=1, `ready_o`=0, `busy_o`=0, `fault_o`=0, `fault_ch_o`=0, state OFF, channel index 0.
- Reset mid-sequence drops all enables on the next edge. There is no ordered power-down on reset.
- States: OFF, UP_SETTLE, UP_WAIT_PG, ON, DN_SETTLE, FAULT.
- **OFF**, `pwr_req_i`=1: set `sw_en_o[0]`, load counter with SETTLE_CYC−1, go to UP_SETTLE with ch=0.
- **UP_SETTLE**: count down. When the counter is 0, go to UP_WAIT_PG and clear the counter.
- **UP_WAIT_PG**:
  - `pg_i[ch]`=1 and ch<N_CH−1: set `sw_en_o[ch+1]`, increment ch, go to UP_SETTLE.
  - `pg_i[ch]`=1 and ch=N_CH−1: go to ON.
- **ON**: `iso_o`=0, `ready_o`=1.
  - `pwr_req_i`=0: clear `sw_en_o[N_CH−1]`, load the settle counter, go to DN_SETTLE with ch=N_CH−1.
  - Any `pg_i` bit 0: go to FAULT. Fault takes priority over the request drop in the same cycle.
- **Abort during power-up**: `pwr_req_i`=0 in UP_SETTLE or UP_WAIT_PG clears `sw_en_o[ch]` and enters DN_SETTLE at the current ch.
- **DN_SETTLE**: count down. When the counter is 0:
  - ch>0: clear `sw_en_o[ch−1]`, decrement ch, reload.
  - ch=0: go to OFF.
  - `pwr_req_i` is ignored until OFF. Re-request takes effect from OFF.
- **FAULT**:
  - On entry: all `sw_en_o` cleared on the same edge, `iso_o`=1, `ready_o`=0, `fault_o`=1, `fault_ch_o` latched.
  - In ON, `fault_ch_o` is the lowest-index `pg_i` bit that is 0.
  - Exit to OFF only when `clr_fault_i`=1 and `pwr_req_i`=0 in the same cycle. `clr_fault_i` with the request high is ignored.
- `busy_o`=1 in UP_SETTLE, UP_WAIT_PG and DN_SETTLE.
- `iso_o`=0 only in ON.

## Timing
- All outputs are registered and change on the transition edge. No combinational path from input to output.
- Power-up: `pwr_req_i` sampled high in OFF at edge t.
  - `sw_en_o[0]`=1 from t+1.
  - Each channel costs SETTLE_CYC+1 cycles when pg is already high.
  - `ready_o`=1 from t+1+N_CH·(SETTLE_CYC+1).
- Power-down: `pwr_req_i` sampled low in ON at edge d.
  - `iso_o`=1 and `sw_en_o[N_CH−1]`=0 at d+1.
  - `sw_en_o[k]` clears at d+1+(N_CH−1−k)·SETTLE_CYC.
  - OFF, with `busy_o`=0, at d+1+N_CH·SETTLE_CYC.
- The counter saturates at 2^CNT_W−1 and never wraps.

## Configuration
- `RIIO_VSUP_TIMEOUT_EN` defined: UP_WAIT_PG is entered at cycle w. If `pg_i[ch]` is 0 for cycles w..w+TIMEOUT_CYC−1, the block enters FAULT at w+TIMEOUT_CYC with `fault_ch_o`=ch.
- Not defined: UP_WAIT_PG waits indefinitely, and the `TIMEOUT_CYC` parameter is unused. The ON-state pg-drop fault is always present.

## Structure
- `riio_vsup_pkg`: state enum `vsup_state_e`, parameter default constants, and a `vsup_ch_w(n)` function returning the `fault_ch_o` width.
- One sub-module, `riio_vsup_cnt`, a loadable saturating down/up counter of width `CNT_W`, shared by the settle and timeout functions.

## Test plan
All scenarios use N_CH=4, SETTLE_CYC=4, TIMEOUT_CYC=16.
- **Normal power-up.** `pg_i` tied 4'hF, `pwr_req_i` raised at edge t.
  - `sw_en_o` = 1, 3, 7, F at t+1, t+6, t+11, t+16.
  - `ready_o`=1 and `iso_o`=0 at t+21.
- **Normal power-down.** Drop the request at d from ON.
  - `iso_o`=1 and `sw_en_o`=7 at d+1, then 3, 1, 0 at d+5, d+9, d+13.
  - `busy_o`=0 at d+17.
- **Timeout** (macro defined). `pg_i[2]` held 0.
  - FAULT 16 cycles after ch 2 enters UP_WAIT_PG: `sw_en_o`=0, `fault_o`=1, `fault_ch_o`=2.
  - With the macro undefined, the block stays busy indefinitely.
- **Pg drop in ON.** Clear `pg_i[1]` for one cycle.
  - Next edge: `sw_en_o`=0, `fault_ch_o`=1, `ready_o`=0.
  - `clr_fault_i` with the request high is ignored.
  - `clr_fault_i` with the request low returns to OFF.
- **Abort during power-up.** Drop the request while ch=1 is in UP_SETTLE.
  - `sw_en_o`=1 on the next edge, 0 after 4 more cycles, then OFF.
- **Reset mid-sequence.** Assert `rst` during DN_SETTLE.
  - All outputs at reset values on the next edge.

Source files
------------

// File: rtl/riio_vsup_pkg.sv
// Shared types and defaults for the GF22FDX IO supply sequencer.
// Defines the sequencer state enum, default parameters and the fault index width helper.
package riio_vsup_pkg;

  typedef enum logic [2:0] {
    OFF,
    UP_SETTLE,
    UP_WAIT_PG,
    ON,
    DN_SETTLE,
    FAULT
  } vsup_state_e;

  localparam int VSUP_N_CH_DEF       = 4;
  localparam int VSUP_CNT_W_DEF      = 12;
  localparam int VSUP_SETTLE_CYC_DEF = 100;
  localparam int VSUP_TIMEOUT_CYC_DEF = 1000;

  // A single-channel build still needs a one-bit fault index port
  function automatic int vsup_ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/riio_vsup_cnt.sv
// Loadable saturating down/up counter shared by the settle and power-good timeout timers.
module riio_vsup_cnt
  import riio_vsup_pkg::*;
#(
  parameter int CNT_W = VSUP_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Load wins over counting; both directions stop at their end values instead of wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/riio_vsup_seq.sv
// Multi-channel IO supply sequencer: ascending power-up, descending power-down, isolation and fault capture.
// Optional power-good timeout during power-up is enabled by defining RIIO_VSUP_TIMEOUT_EN.
module riio_vsup_seq
  import riio_vsup_pkg::*;
#(
  parameter int N_CH        = VSUP_N_CH_DEF,
  parameter int CNT_W       = VSUP_CNT_W_DEF,
  parameter int SETTLE_CYC  = VSUP_SETTLE_CYC_DEF,
  parameter int TIMEOUT_CYC = VSUP_TIMEOUT_CYC_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pwr_req_i,
  input  logic [N_CH-1:0]              pg_i,
  input  logic                         clr_fault_i,
  output logic [N_CH-1:0]              sw_en_o,
  output logic                         iso_o,
  output logic                         ready_o,
  output logic                         busy_o,
  output logic                         fault_o,
  output logic [vsup_ch_w(N_CH)-1:0]   fault_ch_o
);

  localparam int CH_W = vsup_ch_w(N_CH);
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(N_CH - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
`ifdef RIIO_VSUP_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
`else
  localparam int timeout_unused = TIMEOUT_CYC;
`endif

  vsup_state_e       state_q, state_n;
  logic [CH_W-1:0]   ch_q, ch_n;
  logic [N_CH-1:0]   sw_en_q, sw_en_n;
  logic              fault_q, fault_n;
  logic [CH_W-1:0]   fault_ch_q, fault_ch_n;
  logic              iso_q, ready_q, busy_q;

  logic              cnt_load, cnt_dec, cnt_inc;
  logic [CNT_W-1:0]  cnt_load_val, cnt_q;
  logic [N_CH-1:0]   ch_mask;
  logic              pg_cur;
  logic [CH_W-1:0]   pg_low_idx;

  riio_vsup_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .inc      (cnt_inc),
    .count    (cnt_q)
  );

  assign ch_mask = N_CH'(1) << ch_q;
  assign pg_cur  = |(pg_i & ch_mask);

  // Lowest-index channel whose power-good has dropped
  always_comb begin
    pg_low_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (!pg_i[i]) pg_low_idx = CH_W'(i);
    end
  end

  always_comb begin
    state_n      = state_q;
    ch_n         = ch_q;
    sw_en_n      = sw_en_q;
    fault_n      = fault_q;
    fault_ch_n   = fault_ch_q;
    cnt_load     = 1'b0;
    cnt_load_val = SETTLE_LD;
    cnt_dec      = 1'b0;
    cnt_inc      = 1'b0;

    case (state_q)
      OFF: begin
        if (pwr_req_i) begin
          sw_en_n  = N_CH'(1);
          ch_n     = '0;
          cnt_load = 1'b1;
          state_n  = UP_SETTLE;
        end
      end
      UP_SETTLE: begin
        if (!pwr_req_i) begin
          sw_en_n  = sw_en_q & ~ch_mask;
          cnt_load = 1'b1;
          state_n  = DN_SETTLE;
        end else if (cnt_q == '0) begin
          cnt_load     = 1'b1;
          cnt_load_val = '0;
          state_n      = UP_WAIT_PG;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      UP_WAIT_PG: begin
        if (!pwr_req_i) begin
          sw_en_n  = sw_en_q & ~ch_mask;
          cnt_load = 1'b1;
          state_n  = DN_SETTLE;
        end else if (pg_cur) begin
          if (ch_q == CH_LAST) begin
            state_n = ON;
          end else begin
            ch_n     = ch_q + CH_W'(1);
            sw_en_n  = sw_en_q | (ch_mask << 1);
            cnt_load = 1'b1;
            state_n  = UP_SETTLE;
          end
`ifdef RIIO_VSUP_TIMEOUT_EN
        end else if (cnt_q == TO_LAST) begin
          sw_en_n    = '0;
          fault_n    = 1'b1;
          fault_ch_n = ch_q;
          state_n    = FAULT;
        end else begin
          cnt_inc = 1'b1;
`endif
        end
      end
      ON: begin
        // A supply collapsing while up outranks a simultaneous power-down request
        if (pg_i != '1) begin
          sw_en_n    = '0;
          fault_n    = 1'b1;
          fault_ch_n = pg_low_idx;
          state_n    = FAULT;
        end else if (!pwr_req_i) begin
          sw_en_n  = sw_en_q & ~(N_CH'(1) << CH_LAST);
          ch_n     = CH_LAST;
          cnt_load = 1'b1;
          state_n  = DN_SETTLE;
        end
      end
      DN_SETTLE: begin
        if (cnt_q == '0) begin
          if (ch_q != '0) begin
            ch_n     = ch_q - CH_W'(1);
            sw_en_n  = sw_en_q & ~(ch_mask >> 1);
            cnt_load = 1'b1;
          end else begin
            state_n = OFF;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      FAULT: begin
        if (clr_fault_i && !pwr_req_i) begin
          fault_n = 1'b0;
          state_n = OFF;
        end
      end
      default: begin
        sw_en_n = '0;
        state_n = OFF;
      end
    endcase
  end

  // Status outputs are registered from the next state so they change on the transition edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= OFF;
      ch_q       <= '0;
      sw_en_q    <= '0;
      fault_q    <= 1'b0;
      fault_ch_q <= '0;
      iso_q      <= 1'b1;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_n;
      ch_q       <= ch_n;
      sw_en_q    <= sw_en_n;
      fault_q    <= fault_n;
      fault_ch_q <= fault_ch_n;
      iso_q      <= (state_n != ON);
      ready_q    <= (state_n == ON);
      busy_q     <= (state_n == UP_SETTLE) || (state_n == UP_WAIT_PG) || (state_n == DN_SETTLE);
    end
  end

  assign sw_en_o    = sw_en_q;
  assign iso_o      = iso_q;
  assign ready_o    = ready_q;
  assign busy_o     = busy_q;
  assign fault_o    = fault_q;
  assign fault_ch_o = fault_ch_q;

endmodule
